// File: rtl/det_ctrl_pkg.sv
// det_ctrl_pkg -- shared definitions for the determinant controller.
//   * FSM state constants and the state_t enum built from them
//   * error codes reported on the controller's error output
//   * matrix size limits and element/flat-bus widths
//   * size_is_legal(): the single place that decides whether a requested
//     matrix order can be handed to the datapath
package det_ctrl_pkg;

  localparam logic [2:0] MIN_SIZE = 3'd2;
  localparam logic [2:0] MAX_SIZE = 3'd5;
  localparam int         ELEM_W   = 8;
  localparam int         FLAT_W   = 200;

  // Raw encodings kept as plain constants so older code that compares
  // against numeric state values keeps working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    WAIT = ST_WAIT,
    DONE = ST_DONE
  } state_t;

  typedef logic [1:0] err_t;
  localparam err_t ERR_NONE    = 2'b00;
  localparam err_t ERR_SIZE    = 2'b01;
  localparam err_t ERR_TIMEOUT = 2'b10;

  function automatic logic size_is_legal(input logic [2:0] size);
    return (size >= MIN_SIZE) && (size <= MAX_SIZE);
  endfunction

endpackage

// File: rtl/det_ctrl_timer.sv
// det_ctrl_timer -- cycle counter shared by the settle and timeout phases.
//   i_clock    : clock, counts on the rising edge
//   i_reset_n  : synchronous active-low reset, clears the count
//   i_load     : clears the count (asserted on every controller state entry)
//   i_enable   : advance the count by one this cycle
//   i_limit    : terminal value to compare against
//   o_tc       : high while the count equals i_limit
// The count saturates at all-ones instead of wrapping.
module det_ctrl_timer #(
  parameter int CNT_W = 6
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/determinant_controller.sv
// determinant_controller -- sequences one determinant request through an
// external datapath: latch the matrix, let the datapath inputs settle,
// wait for completion (optionally bounded), then hold the result until
// the consumer acknowledges it.
//
// Ports
//   clock, reset_n        : clock and synchronous active-low reset
//   start, matrix_size,
//   A_flat                : request strobe, order (2..5) and 8-bit elements
//   ack                   : consumer acknowledge of the held result
//   dp_A_flat,
//   dp_matrix_size        : registered request presented to the datapath
//   dp_number, dp_done,
//   dp_overflow           : datapath result, completion and overflow
//   busy                  : high whenever the controller is not idle
//   result_valid, result,
//   overflow, error       : captured outcome (error 00 ok, 01 size, 10 timeout)
//
// Build option
//   DET_CTRL_TIMEOUT_EN   : when defined, WAIT aborts with error 10 after
//                           TIMEOUT_CYCLES cycles without dp_done; when not
//                           defined WAIT waits indefinitely.
//
// Timing: result_valid is a register that follows the DONE state by one
// cycle, so it rises one cycle after DONE is entered and falls one cycle
// after the ack that leaves DONE. result/overflow/error only change on an
// accepted start or on leaving WAIT, so they are stable while it is high.
module determinant_controller
  import det_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        matrix_size,
  input  logic [FLAT_W-1:0] A_flat,
  input  logic              ack,
  output logic [FLAT_W-1:0] dp_A_flat,
  output logic [2:0]        dp_matrix_size,
  input  logic [ELEM_W-1:0] dp_number,
  input  logic              dp_done,
  input  logic              dp_overflow,
  output logic              busy,
  output logic              result_valid,
  output logic [ELEM_W-1:0] result,
  output logic              overflow,
  output logic [1:0]        error
);

  localparam int MAX_CYC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The timer starts at 0 on state entry and is compared against N-1, so a
  // phase of N cycles leaves on the N-th edge after entry.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
`ifdef DET_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [FLAT_W-1:0] r_dp_a_flat;
  logic [2:0]        r_dp_size;
  logic [ELEM_W-1:0] r_result;
  logic              r_overflow;
  err_t              r_error;
  logic              r_result_valid;

  logic              w_timer_load;
  logic              w_timer_en;
  logic [CNT_W-1:0]  w_timer_limit;
  logic              w_timer_tc;

  // ---------------------------------------------------------------- timer
  assign w_timer_load = (w_state_next != r_state);

`ifdef DET_CTRL_TIMEOUT_EN
  assign w_timer_en    = (r_state == LOAD) || (r_state == WAIT);
  assign w_timer_limit = (r_state == WAIT) ? TIMEOUT_LAST : SETTLE_LAST;
`else
  assign w_timer_en    = (r_state == LOAD);
  assign w_timer_limit = SETTLE_LAST;
`endif

  det_ctrl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_load    (w_timer_load),
    .i_enable  (w_timer_en),
    .i_limit   (w_timer_limit),
    .o_tc      (w_timer_tc)
  );

  // ------------------------------------------------------------ next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = size_is_legal(matrix_size) ? LOAD : DONE;
        end
      end
      LOAD: begin
        // dp_done is deliberately ignored here: it may still be high from
        // the previous request while the new inputs settle.
        if (w_timer_tc) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (dp_done) begin
          w_state_next = DONE;
        end
`ifdef DET_CTRL_TIMEOUT_EN
        else if (w_timer_tc) begin
          w_state_next = DONE;
        end
`endif
      end
      DONE: begin
        // A start arriving with ack is dropped; it must be repeated in IDLE.
        if (ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ state and data
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_dp_a_flat    <= '0;
      r_dp_size      <= '0;
      r_result       <= '0;
      r_overflow     <= 1'b0;
      r_error        <= ERR_NONE;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_result_valid <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dp_a_flat <= A_flat;
            r_dp_size   <= matrix_size;
            if (!size_is_legal(matrix_size)) begin
              r_result   <= '0;
              r_overflow <= 1'b0;
              r_error    <= ERR_SIZE;
            end
          end
        end
        WAIT: begin
          if (dp_done) begin
            r_result   <= dp_number;
            r_overflow <= dp_overflow;
            r_error    <= ERR_NONE;
          end
`ifdef DET_CTRL_TIMEOUT_EN
          else if (w_timer_tc) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_error    <= ERR_TIMEOUT;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign dp_A_flat      = r_dp_a_flat;
  assign dp_matrix_size = r_dp_size;
  assign busy           = (r_state != IDLE);
  assign result_valid   = r_result_valid;
  assign result         = r_result;
  assign overflow       = r_overflow;
  assign error          = r_error;

endmodule

// File: tb/tb_determinant_controller.sv
// tb_determinant_controller -- randomized self-checking bench.
// Each request is predicted from the controller's rules with plain
// arithmetic: the edge at which dp_done is first seen in WAIT (or the
// timeout edge) decides latency and captured values.
module tb_determinant_controller;
  import det_ctrl_pkg::FLAT_W;

  localparam int S = 2;
  localparam int T = 32;
`ifdef DET_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int BOUND = 400;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [2:0]        matrix_size;
  logic [FLAT_W-1:0] A_flat;
  logic              ack;
  logic [FLAT_W-1:0] dp_A_flat;
  logic [2:0]        dp_matrix_size;
  logic [7:0]        dp_number;
  logic              dp_done;
  logic              dp_overflow;
  logic              busy;
  logic              result_valid;
  logic [7:0]        result;
  logic              overflow;
  logic [1:0]        error;

  int n_vectors     = 0;
  int n_miscompares = 0;
  int n_txn         = 0;

  always #5 clock = ~clock;

  determinant_controller #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .matrix_size    (matrix_size),
    .A_flat         (A_flat),
    .ack            (ack),
    .dp_A_flat      (dp_A_flat),
    .dp_matrix_size (dp_matrix_size),
    .dp_number      (dp_number),
    .dp_done        (dp_done),
    .dp_overflow    (dp_overflow),
    .busy           (busy),
    .result_valid   (result_valid),
    .result         (result),
    .overflow       (overflow),
    .error          (error)
  );

  task automatic check(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [FLAT_W-1:0] rand_flat();
    logic [FLAT_W-1:0] v = '0;
    for (int w = 0; w < 7; w++) v = (v << 32) | FLAT_W'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; ack = 1'b0; dp_done = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string where);
    check({where, ".busy"},  FLAT_W'(busy), '0);
    check({where, ".valid"}, FLAT_W'(result_valid), '0);
    check({where, ".result"}, FLAT_W'(result), '0);
    check({where, ".ovf"},   FLAT_W'(overflow), '0);
    check({where, ".error"}, FLAT_W'(error), '0);
    check({where, ".dpA"},   dp_A_flat, '0);
    check({where, ".dpsz"},  FLAT_W'(dp_matrix_size), '0);
  endtask

  // k: first start-relative edge index at which dp_done is high (stays high
  //    afterwards); k < 0 means dp_done never rises.
  task automatic run_txn(input logic [2:0] size, input logic [FLAT_W-1:0] a, input int k,
                         input logic [7:0] num, input logic ovf, input bit ack_with_start);
    bit   legal = (size >= 3'd2) && (size <= 3'd5);
    int   exp_lat;
    logic [1:0] exp_err;
    logic [7:0] exp_res;
    logic exp_ovf;
    int   lat = -1;
    bit   busy_ok = 1'b1;
    int   done_edge;
    int   h;

    // reference model
    if (!legal) begin
      exp_lat = 1; exp_err = 2'b01; exp_res = 8'd0; exp_ovf = 1'b0;
    end else begin
      done_edge = (k < 0) ? -1 : ((k > S + 1) ? k : S + 1);
      if (TO_EN && (done_edge < 0 || done_edge > S + T)) begin
        exp_lat = S + T + 1; exp_err = 2'b10; exp_res = 8'd0; exp_ovf = 1'b0;
      end else begin
        exp_lat = done_edge + 1; exp_err = 2'b00; exp_res = num; exp_ovf = ovf;
      end
    end

    start = 1'b1; matrix_size = size; A_flat = a;
    dp_number = num; dp_overflow = ovf; ack = 1'b0;
    dp_done = (k == 0);
    for (int j = 0; j < BOUND; j++) begin
      step();
      if (result_valid) begin
        lat = j;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      // stray requests while busy must be ignored
      start = ($urandom_range(3) == 0);
      if (start) begin
        matrix_size = 3'($urandom);
        A_flat = rand_flat();
      end
      dp_done = (k >= 0) && (j + 1 >= k);
    end
    start = 1'b0;

    n_txn++;
    $display("txn %0d: size=%0d k=%0d latency=%0d (model %0d) result=%0d err=%0d", n_txn, size, k, lat, exp_lat, result, error);
    check("latency", FLAT_W'(lat), FLAT_W'(exp_lat));
    if (lat < 0) begin
      do_reset();
      return;
    end
    check("busy_during", FLAT_W'(busy_ok), FLAT_W'(1));
    check("result", FLAT_W'(result), FLAT_W'(exp_res));
    check("overflow", FLAT_W'(overflow), FLAT_W'(exp_ovf));
    check("error", FLAT_W'(error), FLAT_W'(exp_err));
    check("dp_A_flat", dp_A_flat, a);
    check("dp_size", FLAT_W'(dp_matrix_size), FLAT_W'(size));

    // hold phase: datapath noise and stray starts must not disturb the result
    h = $urandom_range(3);
    for (int i = 0; i < h; i++) begin
      start = $urandom_range(1); dp_done = $urandom_range(1);
      dp_number = 8'($urandom); dp_overflow = $urandom_range(1);
      step();
    end
    check("hold_valid", FLAT_W'(result_valid), FLAT_W'(1));
    check("hold_result", FLAT_W'(result), FLAT_W'(exp_res));
    check("hold_error", FLAT_W'(error), FLAT_W'(exp_err));

    ack = 1'b1; start = ack_with_start;
    step();
    ack = 1'b0; start = 1'b0; dp_done = 1'b0;
    check("ack_busy", FLAT_W'(busy), '0);
    step();
    check("ack_valid", FLAT_W'(result_valid), '0);
    check("ack_nostart", FLAT_W'(busy), '0);
    check("ack_dpA", dp_A_flat, a);
  endtask

  initial begin
    logic [FLAT_W-1:0] a4;
    reset_n = 1'b0; start = 1'b0; ack = 1'b0; matrix_size = 3'd0; A_flat = '0;
    dp_number = 8'd0; dp_done = 1'b0; dp_overflow = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check_all_zero("reset");

    // 2x2 [3,1,2,4], done two cycles after WAIT entry
    a4 = '0;
    a4[31:0] = {8'd4, 8'd2, 8'd1, 8'd3};
    run_txn(3'd2, a4, S + 2, 8'd10, 1'b0, 1'b0);
    // illegal size
    run_txn(3'd7, rand_flat(), S + 2, 8'd55, 1'b1, 1'b0);
    // stale dp_done through LOAD
    run_txn(3'd4, rand_flat(), 0, 8'd200, 1'b1, 1'b1);
    // dp_done never / very late: timeout or indefinite wait
    if (TO_EN) run_txn(3'd3, rand_flat(), -1, 8'd9, 1'b1, 1'b0);
    else       run_txn(3'd3, rand_flat(), S + 1 + 200, 8'd9, 1'b1, 1'b0);

    // reset in the middle of WAIT
    start = 1'b1; matrix_size = 3'd3; A_flat = rand_flat(); dp_done = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < S + 4; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_all_zero("midwait_reset");
    run_txn(3'd5, rand_flat(), S + 3, 8'd77, 1'b0, 1'b0);

    // randomized requests
    for (int n = 0; n < 24; n++) begin
      run_txn(3'($urandom), rand_flat(), int'($urandom_range(S + 6)),
              8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
